// File: rtl/spart_pkg.sv
// spart_pkg: SPART bus address encodings, baud select type, divisor
// lookup and the driver state type shared by the spart_driver slice.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    typedef enum logic [1:0] {
        BR_4800  = 2'b00,
        BR_9600  = 2'b01,
        BR_19200 = 2'b10,
        BR_38400 = 2'b11
    } br_cfg_t;

    typedef enum logic [2:0] {
        INIT_LO,
        INIT_HI,
        IDLE,
        RX_READ,
        RX_GUARD,
        TX_WRITE,
        TX_GUARD
    } drv_state_t;

    // Reference table: 50 MHz system clock, 16x oversampling.
    localparam int unsigned REF_CLK_FREQ = 50_000_000;
    localparam logic [15:0] DIV_50M_4800  = 16'd650;
    localparam logic [15:0] DIV_50M_9600  = 16'd325;
    localparam logic [15:0] DIV_50M_19200 = 16'd162;
    localparam logic [15:0] DIV_50M_38400 = 16'd80;

    // Elaboration-time divisor lookup; other clock rates fall back to a
    // truncating clk/(16*baud)-1 estimate.
    function automatic logic [15:0] baud_divisor(input br_cfg_t cfg, input int unsigned clk_freq);
        logic [15:0] div;
        int unsigned baud;
        case (cfg)
            BR_4800:  begin baud = 4800;  div = DIV_50M_4800;  end
            BR_9600:  begin baud = 9600;  div = DIV_50M_9600;  end
            BR_19200: begin baud = 19200; div = DIV_50M_19200; end
            default:  begin baud = 38400; div = DIV_50M_38400; end
        endcase
        if (clk_freq != REF_CLK_FREQ) begin
            div = 16'((clk_freq / (16 * baud)) - 1);
        end
        return div;
    endfunction

endpackage

// File: rtl/spart_driver_if.sv
// spart_driver_if: SPART processor-bus control and status signals.
// The 8-bit databus is bidirectional and stays a plain inout port.
interface spart_driver_if;

    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
    modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);

endinterface

// File: rtl/spart_driver_echo_fifo.sv
// echo_fifo: byte circular buffer with one-bit-wider pointers so that
// full and empty are distinguishable without a separate counter.
module echo_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Pointer advance; guarded so overflow/underflow cannot corrupt state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/spart_driver.sv
// spart_driver: CPU-side SPART initiator. Programs the baud divisor from
// br_cfg, then echoes every received byte back through a small FIFO.
// Optional: define SPART_DRV_UPCASE_EN to fold a-z to A-Z at FIFO push.
module spart_driver
    import spart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLK_FREQ   = 50_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   br_cfg,
    spart_driver_if.master               bus,
    inout  wire  [7:0]                   databus,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam logic [15:0] DIV_4800  = baud_divisor(BR_4800,  CLK_FREQ);
    localparam logic [15:0] DIV_9600  = baud_divisor(BR_9600,  CLK_FREQ);
    localparam logic [15:0] DIV_19200 = baud_divisor(BR_19200, CLK_FREQ);
    localparam logic [15:0] DIV_38400 = baud_divisor(BR_38400, CLK_FREQ);

    drv_state_t  state_q;
    drv_state_t  state_d;
    logic [1:0]  cfg_q;
    logic        cfg_ld;
    logic [15:0] div_sel;

    logic        acc_cs;
    logic        acc_rw;
    logic [1:0]  acc_addr;
    logic [7:0]  acc_wdata;

    logic        push;
    logic        pop;
    logic [7:0]  push_data;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;

    echo_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef SPART_DRV_UPCASE_EN
    assign push_data = (databus >= 8'h61 && databus <= 8'h7A) ? databus - 8'h20 : databus;
`else
    assign push_data = databus;
`endif

    // Divisor for the currently selected baud rate.
    always_comb begin
        div_sel = DIV_38400;
        case (br_cfg)
            2'b00:   div_sel = DIV_4800;
            2'b01:   div_sel = DIV_9600;
            2'b10:   div_sel = DIV_19200;
            default: div_sel = DIV_38400;
        endcase
    end

    // State register and the configuration snapshot taken in INIT_HI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT_LO;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_ld) begin
                cfg_q <= br_cfg;
            end
        end
    end

    // Next-state logic and the single-cycle bus access for each state.
    always_comb begin
        state_d   = state_q;
        acc_cs    = 1'b0;
        acc_rw    = 1'b1;
        acc_addr  = ADDR_BUF;
        acc_wdata = '0;
        push      = 1'b0;
        pop       = 1'b0;
        cfg_ld    = 1'b0;
        unique case (state_q)
            INIT_LO: begin
                acc_cs    = 1'b1;
                acc_rw    = 1'b0;
                acc_addr  = ADDR_DB_LO;
                acc_wdata = div_sel[7:0];
                state_d   = INIT_HI;
            end
            INIT_HI: begin
                acc_cs    = 1'b1;
                acc_rw    = 1'b0;
                acc_addr  = ADDR_DB_HI;
                acc_wdata = div_sel[15:8];
                cfg_ld    = 1'b1;
                state_d   = IDLE;
            end
            IDLE: begin
                if (br_cfg != cfg_q) begin
                    state_d = INIT_LO;
                end else if (bus.rda && !fifo_full) begin
                    state_d = RX_READ;
                end else if (!fifo_empty && bus.tbr) begin
                    state_d = TX_WRITE;
                end
            end
            RX_READ: begin
                acc_cs  = 1'b1;
                push    = 1'b1;
                state_d = RX_GUARD;
            end
            RX_GUARD: begin
                state_d = IDLE;
            end
            TX_WRITE: begin
                acc_cs    = 1'b1;
                acc_rw    = 1'b0;
                acc_wdata = fifo_dout;
                pop       = 1'b1;
                state_d   = TX_GUARD;
            end
            TX_GUARD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT_LO;
            end
        endcase
    end

    // The state resets to INIT_LO, which is itself an access state, so
    // the bus outputs are qualified with rst_n to go quiet immediately.
    assign bus.iocs   = acc_cs & rst_n;
    assign bus.iorw   = acc_rw | ~rst_n;
    assign bus.ioaddr = rst_n ? acc_addr : ADDR_BUF;
    assign databus    = (rst_n && acc_cs && !acc_rw) ? acc_wdata : 8'hzz;

endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver: directed bench with a SPART bus model and an echo
// scoreboard (expected bytes queued on read, compared on write).
module tb_spart_driver;
    import spart_pkg::*;

    localparam int unsigned FIFO_DEPTH = 4;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [1:0]                   br_cfg;
    wire  [7:0]                   databus;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    spart_driver_if bus_if();

    spart_driver #(.FIFO_DEPTH(FIFO_DEPTH), .CLK_FREQ(50_000_000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .br_cfg     (br_cfg),
        .bus        (bus_if.master),
        .databus    (databus),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    logic [7:0]  rx_q [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  rx_head = 8'h00;
    logic [7:0]  exp_b;
    logic        probe_oe = 1'b0;
    logic        rd_pend = 1'b0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          db_cnt = 0;
    int unsigned rd_cyc = 0;
    int unsigned wr_cyc = 0;
    logic [7:0]  db_lo = 8'h00;
    logic [7:0]  db_hi = 8'h00;
    int          base;

    // SPART drives the bus on buffer reads; the probe drives 00 to test release.
    assign databus = (bus_if.iocs && bus_if.iorw && bus_if.ioaddr == ADDR_BUF) ? rx_head :
                     (probe_oe ? 8'h00 : 8'hzz);

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef SPART_DRV_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    // SPART model and bus monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        if (rd_pend) begin
            rx_q.delete(0);
            rd_pend = 1'b0;
        end
        if (bus_if.iocs && rst_n) begin
            if (bus_if.iorw && bus_if.ioaddr == ADDR_BUF) begin
                exp_q.push_back(echo_of(rx_head));
                rd_pend = 1'b1;
                rd_cnt++;
                rd_cyc = cyc;
            end else if (!bus_if.iorw && bus_if.ioaddr == ADDR_BUF) begin
                wr_cnt++;
                wr_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    assert (1'b0) else begin
                        errors++;
                        $error("FAIL tx_unexpected observed=%h expected=none", databus);
                    end
                end else begin
                    exp_b = exp_q.pop_front();
                    assert (databus === exp_b) else begin
                        errors++;
                        $error("FAIL tx_data observed=%h expected=%h", databus, exp_b);
                    end
                end
            end else if (!bus_if.iorw && bus_if.ioaddr == ADDR_DB_LO) begin
                db_lo = databus;
                db_cnt++;
            end else if (!bus_if.iorw && bus_if.ioaddr == ADDR_DB_HI) begin
                db_hi = databus;
                db_cnt++;
            end
        end
        rx_head    = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        bus_if.rda = (rx_q.size() != 0) && !rd_pend;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rd(input int n, input string tag);
        for (int i = 0; i < 200 && rd_cnt < n; i++) step();
        chk(tag, 16'(rd_cnt >= n), 16'd1);
    endtask

    task automatic wait_wr(input int n, input string tag);
        for (int i = 0; i < 200 && wr_cnt < n; i++) step();
        chk(tag, 16'(wr_cnt >= n), 16'd1);
    endtask

    task automatic wait_db(input int n, input string tag);
        for (int i = 0; i < 200 && db_cnt < n; i++) step();
        chk(tag, 16'(db_cnt >= n), 16'd1);
    endtask

    initial begin
        br_cfg     = 2'b01;
        bus_if.tbr = 1'b0;
        rst_n      = 1'b0;
        repeat (3) step();

        // Reset state.
        chk("rst_iocs",   16'(bus_if.iocs),   16'h0);
        chk("rst_iorw",   16'(bus_if.iorw),   16'h1);
        chk("rst_ioaddr", 16'(bus_if.ioaddr), 16'h0);
        chk("rst_count",  16'(fifo_count),    16'h0);
        probe_oe = 1'b1;
        #1;
        chk("rst_databus_released", 16'(databus), 16'h0);
        probe_oe = 1'b0;

        // Divisor programming after release, 9600 baud.
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("init_lo_iocs", 16'(bus_if.iocs),   16'h1);
        chk("init_lo_iorw", 16'(bus_if.iorw),   16'h0);
        chk("init_lo_addr", 16'(bus_if.ioaddr), 16'h2);
        chk("init_lo_data", 16'(databus),       16'h45);
        step();
        chk("init_hi_iocs", 16'(bus_if.iocs),   16'h1);
        chk("init_hi_addr", 16'(bus_if.ioaddr), 16'h3);
        chk("init_hi_data", 16'(databus),       16'h01);
        step();
        chk("idle_iocs",    16'(bus_if.iocs),   16'h0);

        // Single echo and its latency.
        bus_if.tbr = 1'b1;
        rx_q.push_back(8'h41);
        wait_rd(rd_cnt + 1, "echo_read_timeout");
        chk("echo_cnt_at_read", 16'(fifo_count), 16'h0);
        step();
        chk("echo_cnt_after_read", 16'(fifo_count), 16'h1);
        wait_wr(wr_cnt + 1, "echo_write_timeout");
        chk("echo_latency", 16'(wr_cyc - rd_cyc), 16'd3);
        chk("echo_cnt_at_write", 16'(fifo_count), 16'h1);
        step();
        chk("echo_cnt_after_write", 16'(fifo_count), 16'h0);

        // Backpressure: FIFO fills, fifth byte stays in the SPART.
        bus_if.tbr = 1'b0;
        base = rd_cnt;
        for (int b = 0; b < 5; b++) rx_q.push_back(8'h10 + 8'(b));
        wait_rd(base + 4, "full_read_timeout");
        repeat (10) step();
        chk("full_reads", 16'(rd_cnt - base), 16'd4);
        chk("full_count", 16'(fifo_count),    16'd4);
        bus_if.tbr = 1'b1;
        wait_wr(wr_cnt + 5, "drain_write_timeout");
        chk("drain_reads", 16'(rd_cnt - base), 16'd5);
        repeat (3) step();
        chk("drain_count", 16'(fifo_count), 16'd0);

        // Reconfiguration from IDLE keeps buffered bytes.
        bus_if.tbr = 1'b0;
        base = rd_cnt;
        rx_q.push_back(8'h21);
        rx_q.push_back(8'h22);
        wait_rd(base + 2, "recfg_read_timeout");
        repeat (3) step();
        chk("recfg_count_before", 16'(fifo_count), 16'd2);
        base = db_cnt;
        br_cfg = 2'b11;
        wait_db(base + 2, "recfg_div_timeout");
        chk("recfg_div_lo", 16'(db_lo), 16'h50);
        chk("recfg_div_hi", 16'(db_hi), 16'h00);
        chk("recfg_count_kept", 16'(fifo_count), 16'd2);
        bus_if.tbr = 1'b1;
        wait_wr(wr_cnt + 2, "recfg_echo_timeout");
        repeat (3) step();

        // Reset in the middle of TX_WRITE.
        bus_if.tbr = 1'b0;
        base = rd_cnt;
        rx_q.push_back(8'h33);
        rx_q.push_back(8'h34);
        wait_rd(base + 2, "mid_rst_read_timeout");
        repeat (3) step();
        bus_if.tbr = 1'b1;
        wait_wr(wr_cnt + 1, "mid_rst_write_timeout");
        rst_n = 1'b0;
        #1;
        chk("mid_rst_iocs", 16'(bus_if.iocs), 16'h0);
        chk("mid_rst_iorw", 16'(bus_if.iorw), 16'h1);
        probe_oe = 1'b1;
        #1;
        chk("mid_rst_databus_released", 16'(databus), 16'h0);
        probe_oe = 1'b0;
        chk("mid_rst_count", 16'(fifo_count), 16'd0);
        exp_q.delete();
        base = db_cnt;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_db(base + 2, "mid_rst_div_timeout");
        chk("mid_rst_div_lo", 16'(db_lo), 16'h50);
        chk("mid_rst_div_hi", 16'(db_hi), 16'h00);
        chk("mid_rst_count_after", 16'(fifo_count), 16'd0);

        // Letter range edges: folded only when the upper-case option is built.
        base = wr_cnt;
        rx_q.push_back(8'h61);
        rx_q.push_back(8'h7B);
        rx_q.push_back(8'h7A);
        rx_q.push_back(8'h60);
        wait_wr(base + 4, "case_echo_timeout");
        repeat (3) step();
        chk("final_count", 16'(fifo_count), 16'd0);
        chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
